// File: rtl/wb_periph_hub_if.sv
// Bus bundle between the SERV data port, the peripheral hub and its N slaves.
// The hub uses the slave modport; the CPU/slave side environment uses master.
interface wb_periph_hub_if #(
    parameter int N = 4
);
    logic [31:0]    wb_dbus_adr;
    logic           wb_dbus_we;
    logic           wb_dbus_cyc;
    logic [31:0]    wb_xbus_rdt;
    logic           wb_xbus_ack;
    logic [N-1:0]   s_cyc;
    logic [N-1:0]   s_ack;
    logic [32*N-1:0] s_rdt;
    logic           err;
    logic [31:0]    err_adr;
    logic           err_clr;

    modport slave (
        input  wb_dbus_adr, wb_dbus_we, wb_dbus_cyc, s_ack, s_rdt, err_clr,
        output wb_xbus_rdt, wb_xbus_ack, s_cyc, err, err_adr
    );

    modport master (
        output wb_dbus_adr, wb_dbus_we, wb_dbus_cyc, s_ack, s_rdt, err_clr,
        input  wb_xbus_rdt, wb_xbus_ack, s_cyc, err, err_adr
    );
endinterface

// File: rtl/wb_periph_hub.sv
// Wishbone peripheral hub: decodes adr[31:24] to one of N slaves and bounds
// every access with a miss/timeout error path so the CPU can never hang.
module wb_periph_hub #(
    parameter int          N        = 4,
    parameter logic [8*N-1:0] BASES = {8'h70, 8'h60, 8'h50, 8'h40},
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hdeadface
) (
    input  logic           wb_clk,
    input  logic           rst_n,
    wb_periph_hub_if.slave bus,
    output logic [1:0]     dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   hit_idx;
    logic            hit;
    logic            sel_ack;
    logic            last_cnt;
    logic            raise;
    logic [CW-1:0]   count;
    logic [31:0]     rdt_q;
    logic [31:0]     sel_rdt;
    logic [N-1:0]    s_cyc_q;
    logic            ack_q;
    logic            err_q;
    logic [31:0]     err_adr_q;

    // Scan from the top so the lowest matching slot wins on overlapping bases.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.wb_dbus_adr[31:24] == BASES[8*i +: 8]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign sel_ack  = bus.s_ack[sel];
    assign sel_rdt  = bus.s_rdt[32*sel +: 32];
    assign last_cnt = (count == CW'(TIMEOUT - 1));

    // A slave ack in the final BUSY cycle outranks the timeout.
    assign raise = ((state == IDLE) && bus.wb_dbus_cyc && !hit) ||
                   ((state == BUSY) && bus.wb_dbus_cyc && !sel_ack && last_cnt);

    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s_cyc_q <= '0;
            ack_q   <= 1'b0;
            rdt_q   <= '0;
            sel     <= '0;
            count   <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wb_dbus_cyc) begin
                        if (hit) begin
                            s_cyc_q          <= '0;
                            s_cyc_q[hit_idx] <= 1'b1;
                            sel              <= hit_idx;
                            count            <= '0;
                            state            <= BUSY;
                        end else begin
                            rdt_q <= ERR_DATA;
                            ack_q <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.wb_dbus_cyc) begin
                        s_cyc_q <= '0;
                        state   <= IDLE;
                    end else if (sel_ack) begin
                        rdt_q   <= sel_rdt;
                        s_cyc_q <= '0;
                        ack_q   <= 1'b1;
                        state   <= DONE;
                    end else if (last_cnt) begin
                        rdt_q   <= ERR_DATA;
                        s_cyc_q <= '0;
                        ack_q   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The first error address is kept until cleared; a raise beats a clear.
    always_ff @(posedge wb_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end else if (raise) begin
            err_q <= 1'b1;
            if (!err_q || bus.err_clr) begin
                err_adr_q <= bus.wb_dbus_adr;
            end
        end else if (bus.err_clr) begin
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end
    end

    assign bus.s_cyc       = s_cyc_q;
    assign bus.wb_xbus_ack = ack_q;
    assign bus.wb_xbus_rdt = ack_q ? rdt_q : 32'h0;
    assign bus.err         = err_q;
    assign bus.err_adr     = err_adr_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_wb_periph_hub.sv
// Directed bench for wb_periph_hub: slave model with programmable ack delay,
// expected read data queued at issue time and compared on wb_xbus_ack.
module tb_wb_periph_hub;
    logic       wb_clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state_b;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    wb_periph_hub_if #(.N(4)) bus ();
    wb_periph_hub_if #(.N(4)) bus_b ();

    always #5 wb_clk = ~wb_clk;

    wb_periph_hub #(.N(4)) dut (
        .wb_clk    (wb_clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    wb_periph_hub #(.N(4), .BASES({8'h40, 8'h60, 8'h50, 8'h40})) dut_b (
        .wb_clk    (wb_clk),
        .rst_n     (rst_n),
        .bus       (bus_b),
        .dbg_state (dbg_state_b)
    );

    // Slave model: selected slave acks once busy_cnt reaches ack_wait.
    logic [31:0] slot_data [4];
    logic        ack_en   = 1'b0;
    int          ack_wait = 0;
    int          busy_cnt = 0;

    always @(posedge wb_clk) busy_cnt <= (bus.s_cyc != 4'b0) ? busy_cnt + 1 : 0;
    assign bus.s_ack   = (ack_en && busy_cnt == ack_wait) ? bus.s_cyc : 4'b0;
    assign bus.s_rdt   = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};
    assign bus_b.s_ack = bus_b.s_cyc;
    assign bus_b.s_rdt = {32'hb3b3_b3b3, 32'hb2b2_b2b2, 32'hb1b1_b1b1, 32'hb0b0_b0b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Waits for the ack of a cycle already raised, checks rdt against the queue,
    // then drops cyc in the cycle after the ack.
    task automatic run_cycle(input string tag, input int max_cyc, output int lat,
                             output int scyc_n, output logic [3:0] scyc_seen);
        bit done;
        bit bad_oh;
        logic [31:0] exp;
        lat = 0; scyc_n = 0; scyc_seen = '0; done = 0; bad_oh = 0;
        for (int k = 1; k <= max_cyc && !done; k++) begin
            @(posedge wb_clk);
            #1 bus.err_clr = 1'b0;
            @(negedge wb_clk);
            if (!$onehot0(bus.s_cyc)) bad_oh = 1;
            if (bus.s_cyc != 4'b0) begin
                scyc_n++;
                scyc_seen = scyc_seen | bus.s_cyc;
            end
            if (bus.wb_xbus_ack) begin
                lat  = k;
                done = 1;
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_ack"}, 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    chk({tag, "_rdt"}, bus.wb_xbus_rdt, exp);
                end
            end
        end
        if (!done) chk({tag, "_ack_bound"}, 32'd0, 32'd1);
        chk({tag, "_onehot"}, 32'(bad_oh), 32'd0);
        @(posedge wb_clk);
        #1 bus.wb_dbus_cyc = 1'b0;
        @(negedge wb_clk);
        chk({tag, "_ack_single"}, 32'(bus.wb_xbus_ack), 32'd0);
    endtask

    task automatic access(input string tag, input logic [31:0] adr, input logic we,
                          input logic clr, input int max_cyc, output int lat,
                          output int scyc_n, output logic [3:0] scyc_seen);
        @(posedge wb_clk);
        #1;
        bus.wb_dbus_adr = adr;
        bus.wb_dbus_we  = we;
        bus.wb_dbus_cyc = 1'b1;
        bus.err_clr     = clr;
        run_cycle(tag, max_cyc, lat, scyc_n, scyc_seen);
    endtask

    task automatic clear_err(input string tag);
        @(posedge wb_clk);
        #1 bus.err_clr = 1'b1;
        @(posedge wb_clk);
        #1 bus.err_clr = 1'b0;
        @(negedge wb_clk);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_err_adr"}, bus.err_adr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int scyc_n;
        logic [3:0] seen;
        bit saw_ack;

        rst_n = 1'b0;
        bus.wb_dbus_adr = '0; bus.wb_dbus_we = 1'b0; bus.wb_dbus_cyc = 1'b0; bus.err_clr = 1'b0;
        bus_b.wb_dbus_adr = '0; bus_b.wb_dbus_we = 1'b0; bus_b.wb_dbus_cyc = 1'b0; bus_b.err_clr = 1'b0;
        for (int i = 0; i < 4; i++) slot_data[i] = $urandom();
        slot_data[1] = 32'h1234_5678;

        repeat (3) @(posedge wb_clk);
        @(negedge wb_clk);
        chk("rst_s_cyc", 32'(bus.s_cyc), 32'h0);
        chk("rst_ack", 32'(bus.wb_xbus_ack), 32'h0);
        chk("rst_rdt", bus.wb_xbus_rdt, 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_err_adr", bus.err_adr, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        @(posedge wb_clk);
        #1 rst_n = 1'b1;

        // Slave 1 acks on its first BUSY cycle.
        ack_en = 1'b1; ack_wait = 0;
        exp_q.push_back(32'h1234_5678);
        access("rd_s1", 32'h5000_0000, 1'b0, 1'b0, 10, lat, scyc_n, seen);
        chk("rd_s1_lat", 32'(lat), 32'd2);
        chk("rd_s1_scyc_n", 32'(scyc_n), 32'd1);
        chk("rd_s1_scyc", 32'(seen), 32'h2);
        chk("rd_s1_err", 32'(bus.err), 32'h0);

        // Write to slave 3 with three wait states.
        ack_wait = 3;
        exp_q.push_back(slot_data[3]);
        access("wr_s3", 32'h7000_0010, 1'b1, 1'b0, 20, lat, scyc_n, seen);
        chk("wr_s3_lat", 32'(lat), 32'd5);
        chk("wr_s3_scyc_n", 32'(scyc_n), 32'd4);
        chk("wr_s3_scyc", 32'(seen), 32'h8);

        // Unmapped address.
        exp_q.push_back(32'hdeadface);
        access("miss", 32'h9000_0004, 1'b0, 1'b0, 10, lat, scyc_n, seen);
        chk("miss_lat", 32'(lat), 32'd1);
        chk("miss_scyc_n", 32'(scyc_n), 32'd0);
        chk("miss_err", 32'(bus.err), 32'h1);
        chk("miss_err_adr", bus.err_adr, 32'h9000_0004);
        clear_err("clr1");

        // Slave 2 never acks: timeout, then a second timeout keeps err_adr.
        ack_en = 1'b0;
        exp_q.push_back(32'hdeadface);
        access("to1", 32'h6000_0000, 1'b0, 1'b0, 30, lat, scyc_n, seen);
        chk("to1_lat", 32'(lat), 32'd17);
        chk("to1_scyc_n", 32'(scyc_n), 32'd16);
        chk("to1_scyc", 32'(seen), 32'h4);
        chk("to1_err", 32'(bus.err), 32'h1);
        chk("to1_err_adr", bus.err_adr, 32'h6000_0000);
        exp_q.push_back(32'hdeadface);
        access("to2", 32'h6000_0100, 1'b0, 1'b0, 30, lat, scyc_n, seen);
        chk("to2_lat", 32'(lat), 32'd17);
        chk("to2_err_adr", bus.err_adr, 32'h6000_0000);
        clear_err("clr2");

        // Ack in the final BUSY cycle beats the timeout.
        ack_en = 1'b1; ack_wait = 15;
        exp_q.push_back(slot_data[0]);
        access("late", 32'h4000_0000, 1'b0, 1'b0, 30, lat, scyc_n, seen);
        chk("late_lat", 32'(lat), 32'd17);
        chk("late_scyc_n", 32'(scyc_n), 32'd16);
        chk("late_scyc", 32'(seen), 32'h1);
        chk("late_err", 32'(bus.err), 32'h0);

        // err_clr coincident with a miss: raise wins, new address captured.
        exp_q.push_back(32'hdeadface);
        access("miss_a", 32'ha000_0000, 1'b0, 1'b0, 10, lat, scyc_n, seen);
        chk("miss_a_err_adr", bus.err_adr, 32'ha000_0000);
        exp_q.push_back(32'hdeadface);
        access("miss_clr", 32'hb000_0008, 1'b0, 1'b1, 10, lat, scyc_n, seen);
        chk("miss_clr_err", 32'(bus.err), 32'h1);
        chk("miss_clr_err_adr", bus.err_adr, 32'hb000_0008);
        clear_err("clr3");

        // CPU drops cyc in BUSY: back to IDLE, no ack, no error.
        ack_en = 1'b0;
        @(posedge wb_clk);
        #1 bus.wb_dbus_adr = 32'h5000_0000; bus.wb_dbus_cyc = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1 bus.wb_dbus_cyc = 1'b0;
        saw_ack = 0;
        @(posedge wb_clk);
        @(negedge wb_clk);
        chk("abort_scyc", 32'(bus.s_cyc), 32'h0);
        chk("abort_state", 32'(dbg_state), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk);
            if (bus.wb_xbus_ack) saw_ack = 1;
        end
        chk("abort_noack", 32'(saw_ack), 32'h0);
        chk("abort_err", 32'(bus.err), 32'h0);

        // Async reset in BUSY, then the pending cycle restarts decode.
        @(posedge wb_clk);
        #1 bus.wb_dbus_adr = 32'h6000_0000; bus.wb_dbus_cyc = 1'b1;
        repeat (2) @(posedge wb_clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_scyc", 32'(bus.s_cyc), 32'h0);
        chk("arst_ack", 32'(bus.wb_xbus_ack), 32'h0);
        chk("arst_state", 32'(dbg_state), 32'h0);
        ack_en = 1'b1; ack_wait = 0;
        exp_q.push_back(slot_data[2]);
        @(posedge wb_clk);
        #1 rst_n = 1'b1;
        run_cycle("arst_restart", 10, lat, scyc_n, seen);
        chk("arst_restart_lat", 32'(lat), 32'd2);
        chk("arst_restart_scyc", 32'(seen), 32'h4);

        // Overlapping bases on the second hub: slot 0 wins.
        @(posedge wb_clk);
        #1 bus_b.wb_dbus_adr = 32'h4000_0000; bus_b.wb_dbus_cyc = 1'b1;
        @(posedge wb_clk);
        @(negedge wb_clk);
        chk("ovl_scyc", 32'(bus_b.s_cyc), 32'h1);
        @(posedge wb_clk);
        @(negedge wb_clk);
        chk("ovl_ack", 32'(bus_b.wb_xbus_ack), 32'h1);
        chk("ovl_rdt", bus_b.wb_xbus_rdt, 32'hb0b0_b0b0);
        @(posedge wb_clk);
        #1 bus_b.wb_dbus_cyc = 1'b0;

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge wb_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
